// File: rtl/spio_scan_pkg.sv
// Shared definitions for the spio_scan peripheral: Wishbone register
// offsets, control/status field positions, scan FSM states and a small
// priority helper used to report the lowest newly pressed key.
package spio_scan_pkg;

   localparam logic [1:0] ADDR_LED    = 2'd0;
   localparam logic [1:0] ADDR_KEYMAP = 2'd1;
   localparam logic [1:0] ADDR_EVENT  = 2'd2;
   localparam logic [1:0] ADDR_MANUAL = 2'd3;

   // AUTO is written through bit 16 but read back at bit 31 of register 0.
   localparam int unsigned AUTO_BIT       = 16;
   localparam int unsigned AUTO_RD_BIT    = 31;
   localparam int unsigned KVALID_BIT     = 31;
   localparam int unsigned KOVR_BIT       = 30;
   localparam int unsigned BVALID_BIT     = 29;
   localparam int unsigned LED_MASK_SHIFT = 8;

   typedef enum logic [1:0] {
      SCAN_IDLE,
      SCAN_DWELL,
      SCAN_SAMPLE
   } scan_state_e;

   // Index of the lowest set bit, 0 when no bit is set.
   function automatic logic [7:0] lowest_set(input logic [31:0] v);
      logic [7:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (v[31-i]) idx = 8'(31 - i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/spio_debounce.sv
// Single push-button conditioner: two-flop synchroniser followed by a
// saturating disagreement counter.
//   clk_i, rst_i : clock and synchronous active-high reset
//   btn_i        : raw asynchronous button level (active high)
//   state_o      : debounced button state
//   rise_o       : one-cycle strobe coincident with the state_d 0->1 update
module spio_debounce #(
   parameter int unsigned DBBITS = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic state_o,
   output logic rise_o
);

   logic [1:0]        sync_q;
   logic              state_q, state_d;
   logic [DBBITS-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised level disagrees with the
   // debounced state; any agreement restarts the qualification period.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sync_q[1] == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == '1) begin
         state_d = sync_q[1];
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;
   assign rise_o  = state_d & ~state_q;

endmodule

// File: rtl/spio_scan.sv
// Special-purpose I/O peripheral: masked LED writes, debounced buttons and
// an autonomous keypad scanner with a 2-frame-agreement key bitmap.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_wb_*/o_wb_*           : Wishbone classic slave, one-cycle registered ack
//   o_kp_col / i_kp_row     : keypad column drive / row sense, active low
//   i_btn                   : raw buttons, active high
//   o_led                   : LED drive
//   o_kp_int, o_btn_int     : level interrupts (kvalid, bvalid)
module spio_scan
   import spio_scan_pkg::*;
#(
   parameter int unsigned NLED   = 4,
   parameter int unsigned NBTN   = 2,
   parameter int unsigned NROW   = 4,
   parameter int unsigned NCOL   = 4,
   parameter int unsigned DWELL  = 1000,
   parameter int unsigned DBBITS = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [1:0]      i_wb_addr,
   input  logic [31:0]     i_wb_data,
   output logic            o_wb_ack,
   output logic [31:0]     o_wb_data,
   output logic [NCOL-1:0] o_kp_col,
   input  logic [NROW-1:0] i_kp_row,
   input  logic [NBTN-1:0] i_btn,
   output logic [NLED-1:0] o_led,
   output logic            o_kp_int,
   output logic            o_btn_int
);

   localparam int unsigned NKEY = NROW * NCOL;
   localparam int unsigned CW   = $clog2(DWELL);
   localparam int unsigned COLW = (NCOL > 1) ? $clog2(NCOL) : 1;

   logic [NROW-1:0] row_s1_q, row_s2_q;
   logic [NLED-1:0] led_q, led_d;
   logic            auto_q, auto_d;
   logic [NCOL-1:0] mcol_q, mcol_d;
   scan_state_e     state_q, state_d;
   logic [COLW-1:0] col_q, col_d;
   logic [CW-1:0]   dcnt_q, dcnt_d;
   logic [NROW-1:0] prev_q [NCOL];
   logic [NKEY-1:0] keymap_q, keymap_d;
   logic            kvalid_q, kvalid_d, kovr_q, kovr_d, bvalid_q, bvalid_d;
   logic [7:0]      kidx_q, kidx_d;
   logic            ack_q;
   logic [31:0]     rdata_q, rdata_d;

   logic            req, wr_led, wr_ev, wr_man;
   logic            sample;
   logic [NROW-1:0] s;
   logic [31:0]     press32;
   logic            press_any, clr_k, clr_b;
   logic [NBTN-1:0] btn_state, btn_rise;
   logic [7:0]      btn8, led8, row8, mcol8;
   logic            unused_wb;

   assign req    = i_wb_cyc & i_wb_stb;
   assign wr_led = req & i_wb_we & (i_wb_addr == ADDR_LED);
   assign wr_ev  = req & i_wb_we & (i_wb_addr == ADDR_EVENT);
   assign wr_man = req & i_wb_we & (i_wb_addr == ADDR_MANUAL);
   assign unused_wb = ^i_wb_data;

   for (genvar b = 0; b < NBTN; b++) begin : g_btn
      spio_debounce #(.DBBITS(DBBITS)) u_db (
         .clk_i   (i_clk),
         .rst_i   (i_reset),
         .btn_i   (i_btn[b]),
         .state_o (btn_state[b]),
         .rise_o  (btn_rise[b])
      );
   end

   // Scan FSM: each column occupies DWELL clocks, DWELL-1 in SCAN_DWELL and
   // the final one in SCAN_SAMPLE. Leaving auto mode parks col/dcnt at 0.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      dcnt_d  = dcnt_q;
      sample  = 1'b0;
      if (!auto_q) begin
         state_d = SCAN_IDLE;
         col_d   = '0;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            SCAN_IDLE: begin
               state_d = SCAN_DWELL;
               col_d   = '0;
               dcnt_d  = '0;
            end
            SCAN_DWELL: begin
               if (dcnt_q == CW'(DWELL - 2)) state_d = SCAN_SAMPLE;
               else                          dcnt_d  = dcnt_q + 1'b1;
            end
            SCAN_SAMPLE: begin
               sample  = 1'b1;
               dcnt_d  = '0;
               state_d = SCAN_DWELL;
               col_d   = (col_q == COLW'(NCOL - 1)) ? '0 : col_q + 1'b1;
            end
            default: state_d = SCAN_IDLE;
         endcase
      end
   end

   // A column's keymap slots only follow the sample when two consecutive
   // frames agree.
   always_comb begin
      keymap_d = keymap_q;
      s        = ~row_s2_q;
      if (sample && (s == prev_q[col_q])) begin
         for (int unsigned c = 0; c < NCOL; c++) begin
            if (col_q == COLW'(c)) begin
               for (int unsigned r = 0; r < NROW; r++) keymap_d[r*NCOL + c] = s[r];
            end
         end
      end
   end

   // Event flags: a press in the same clock as a software clear wins, and
   // the cleared kvalid does not count towards overrun.
   always_comb begin
      press32                = '0;
      press32[NKEY-1:0]      = keymap_d & ~keymap_q;
      press_any              = |press32;
      clr_k                  = wr_ev & i_wb_data[KVALID_BIT];
      clr_b                  = wr_ev & i_wb_data[BVALID_BIT];
      kvalid_d               = kvalid_q;
      kovr_d                 = kovr_q;
      kidx_d                 = kidx_q;
      bvalid_d               = bvalid_q;
      if (clr_k) begin
         kvalid_d = 1'b0;
         kovr_d   = 1'b0;
      end
      if (press_any) begin
         if (kvalid_q && !clr_k) kovr_d = 1'b1;
         kvalid_d = 1'b1;
         kidx_d   = lowest_set(press32);
      end
      if (clr_b)       bvalid_d = 1'b0;
      if (|btn_rise)   bvalid_d = 1'b1;
   end

   always_comb begin
      led_d  = led_q;
      auto_d = auto_q;
      mcol_d = mcol_q;
      if (wr_led) begin
         for (int unsigned k = 0; k < NLED; k++) begin
            if (i_wb_data[LED_MASK_SHIFT + k]) led_d[k] = i_wb_data[k];
         end
         if (i_wb_data[31]) auto_d = i_wb_data[AUTO_BIT];
      end
      if (wr_man) mcol_d = i_wb_data[NCOL-1:0];
   end

   always_comb begin
      btn8              = '0;
      btn8[NBTN-1:0]    = btn_state;
      led8              = '0;
      led8[NLED-1:0]    = led_q;
      row8              = '0;
      row8[NROW-1:0]    = row_s2_q;
      mcol8             = '0;
      mcol8[NCOL-1:0]   = mcol_q;
      rdata_d           = '0;
      case (i_wb_addr)
         ADDR_LED: begin
            rdata_d[AUTO_RD_BIT] = auto_q;
            rdata_d[15:8]        = btn8;
            rdata_d[7:0]         = led8;
         end
         ADDR_KEYMAP: rdata_d[NKEY-1:0] = keymap_q;
         ADDR_EVENT: begin
            rdata_d[KVALID_BIT] = kvalid_q;
            rdata_d[KOVR_BIT]   = kovr_q;
            rdata_d[BVALID_BIT] = bvalid_q;
            rdata_d[7:0]        = kidx_q;
         end
         default: begin
            rdata_d[15:8] = row8;
            rdata_d[7:0]  = mcol8;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         row_s1_q <= '0;
         row_s2_q <= '0;
         led_q    <= '0;
         auto_q   <= 1'b0;
         mcol_q   <= '0;
         state_q  <= SCAN_IDLE;
         col_q    <= '0;
         dcnt_q   <= '0;
         for (int unsigned c = 0; c < NCOL; c++) prev_q[c] <= '0;
         keymap_q <= '0;
         kvalid_q <= 1'b0;
         kovr_q   <= 1'b0;
         bvalid_q <= 1'b0;
         kidx_q   <= '0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         row_s1_q <= i_kp_row;
         row_s2_q <= row_s1_q;
         led_q    <= led_d;
         auto_q   <= auto_d;
         mcol_q   <= mcol_d;
         state_q  <= state_d;
         col_q    <= col_d;
         dcnt_q   <= dcnt_d;
         if (sample) prev_q[col_q] <= s;
         keymap_q <= keymap_d;
         kvalid_q <= kvalid_d;
         kovr_q   <= kovr_d;
         bvalid_q <= bvalid_d;
         kidx_q   <= kidx_d;
         ack_q    <= req;
         if (req) rdata_q <= rdata_d;
      end
   end

   always_comb begin
      if (auto_q) begin
         o_kp_col        = '1;
         o_kp_col[col_q] = 1'b0;
      end else begin
         o_kp_col = mcol_q;
      end
   end

   assign o_wb_ack  = ack_q;
   assign o_wb_data = rdata_q;
   assign o_led     = led_q;
   assign o_kp_int  = kvalid_q;
   assign o_btn_int = bvalid_q;

endmodule

// File: tb/tb_spio_scan.sv
module tb_spio_scan;

   localparam int unsigned FRAME  = 4 * 8;
   localparam int unsigned SETTLE = 3 * FRAME + 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic [3:0]  o_kp_col;
   logic [3:0]  i_kp_row;
   logic [1:0]  i_btn;
   logic [3:0]  o_led;
   logic        o_kp_int, o_btn_int;

   // Physical keypad: key bit r*4+c connects row r to column c.
   logic [15:0] keys;
   logic        ovr_en;
   logic [3:0]  ovr_val;

   // Reference model state
   logic [3:0]  m_led, m_mcol;
   logic        m_auto, m_kvalid, m_kovr, m_bvalid;
   logic [1:0]  m_btn;
   logic [15:0] m_keymap;
   logic [7:0]  m_kidx;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sbq[$];
   sb_t mon_e;

   spio_scan #(.NLED(4), .NBTN(2), .NROW(4), .NCOL(4), .DWELL(8), .DBBITS(4)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
      .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
      .o_kp_col(o_kp_col), .i_kp_row(i_kp_row), .i_btn(i_btn), .o_led(o_led),
      .o_kp_int(o_kp_int), .o_btn_int(o_btn_int)
   );

   always #5 clk = ~clk;

   always_comb begin
      i_kp_row = 4'hF;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            if (!o_kp_col[c] && keys[r*4 + c]) i_kp_row[r] = 1'b0;
      if (ovr_en) i_kp_row = ovr_val;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every acknowledge consumes one scoreboard entry.
   always @(negedge clk) begin
      if (!rst && o_wb_ack) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=1 required=0");
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) chk(mon_e.name, o_wb_data, mon_e.exp);
         end
      end
   end

   function automatic logic [31:0] exp_reg(input logic [1:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         2'd0: begin v[31] = m_auto; v[9:8] = m_btn; v[3:0] = m_led; end
         2'd1: v[15:0] = m_keymap;
         2'd2: begin v[31] = m_kvalid; v[30] = m_kovr; v[29] = m_bvalid; v[7:0] = m_kidx; end
         default: begin v[11:8] = i_kp_row; v[3:0] = m_mcol; end
      endcase
      return v;
   endfunction

   task automatic wb_cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input bit c, input logic [31:0] e, input string nm);
      sb_t ent;
      @(negedge clk);
      ent.chk = c; ent.exp = e; ent.name = nm;
      sbq.push_back(ent);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input string nm);
      wb_cycle(1'b0, a, '0, 1'b1, exp_reg(a), nm);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wb_cycle(1'b1, a, d, 1'b0, '0, "write");
      case (a)
         2'd0: begin
            for (int unsigned k = 0; k < 4; k++) if (d[8+k]) m_led[k] = d[k];
            if (d[31]) m_auto = d[16];
         end
         2'd2: begin
            if (d[31]) begin m_kvalid = 1'b0; m_kovr = 1'b0; end
            if (d[29]) m_bvalid = 1'b0;
         end
         2'd3: m_mcol = d[3:0];
         default: ;
      endcase
   endtask

   // Keymap tracks the physical keys once scanning has settled; a newly
   // pressed key raises an event.
   task automatic model_keys();
      logic [15:0] nw;
      if (m_auto) begin
         nw = keys & ~m_keymap;
         if (nw != 0) begin
            for (int unsigned i = 0; i < 16; i++)
               if (nw[i]) begin m_kidx = 8'(i); break; end
            if (m_kvalid) m_kovr = 1'b1;
            m_kvalid = 1'b1;
         end
         m_keymap = keys;
      end
   endtask

   task automatic settle_keys();
      repeat (SETTLE) @(negedge clk);
      model_keys();
   endtask

   task automatic btn_hold(input int unsigned b, input int unsigned n);
      @(negedge clk);
      i_btn[b] = 1'b1;
      repeat (n) @(negedge clk);
      m_btn[b] = 1'b1;
      m_bvalid = 1'b1;
      rd(2'd0, "btn_held_reg0");
      i_btn[b] = 1'b0;
      repeat (24) @(negedge clk);
      m_btn[b] = 1'b0;
      rd(2'd0, "btn_released_reg0");
      rd(2'd2, "btn_event_reg2");
   endtask

   task automatic btn_glitch(input int unsigned b, input int unsigned n);
      @(negedge clk);
      i_btn[b] = 1'b1;
      repeat (n) @(negedge clk);
      i_btn[b] = 1'b0;
      repeat (24) @(negedge clk);
      rd(2'd0, "glitch_reg0");
      rd(2'd2, "glitch_reg2");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned n;
      logic [31:0] d;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      i_btn = '0; keys = '0; ovr_en = 1'b0; ovr_val = 4'hF;
      m_led = '0; m_mcol = '0; m_auto = 1'b0; m_kvalid = 1'b0; m_kovr = 1'b0;
      m_bvalid = 1'b0; m_btn = '0; m_keymap = '0; m_kidx = '0;
      repeat (3) @(negedge clk);
      chk("rst_kp_col", o_kp_col, 0);
      chk("rst_led", o_led, 0);
      chk("rst_kp_int", o_kp_int, 0);
      chk("rst_btn_int", o_btn_int, 0);
      chk("rst_ack", o_wb_ack, 0);
      chk("rst_rdata", o_wb_data, 0);
      rst = 1'b0;
      rd(2'd0, "rst_reg0");
      rd(2'd1, "rst_reg1");
      rd(2'd2, "rst_reg2");
      rd(2'd3, "rst_reg3");

      // Masked LED writes
      wr(2'd0, 32'h0000_0305);
      chk("led_first", o_led, 4'b0001);
      wr(2'd0, 32'h0000_0C08);
      chk("led_second", o_led, 4'b1001);
      rd(2'd0, "led_reg0");

      // Auto scan, key 9 (row 2, col 1)
      wr(2'd0, 32'h8001_0000);
      keys[9] = 1'b1;
      n = 0;
      while (!o_kp_int && n < SETTLE) begin @(negedge clk); n++; end
      chk("kp_int_latency", o_kp_int, 1);
      model_keys();
      rd(2'd1, "key9_keymap");
      rd(2'd2, "key9_event");
      wr(2'd2, 32'h8000_0000);
      rd(2'd2, "kvalid_cleared");

      // Re-press 9, then 4 without clearing -> overrun
      keys[9] = 1'b0; settle_keys();
      keys[9] = 1'b1; settle_keys();
      keys[4] = 1'b1; settle_keys();
      rd(2'd1, "key9_4_keymap");
      rd(2'd2, "key4_overrun");

      // One-frame bounce on key 0 must not reach the keymap
      keys[0] = 1'b1;
      repeat (FRAME - 4) @(negedge clk);
      keys[0] = 1'b0;
      settle_keys();
      rd(2'd1, "bounce_keymap");
      rd(2'd2, "bounce_event");

      keys[9] = 1'b0; keys[4] = 1'b0; settle_keys();
      wr(2'd2, 32'hA000_0000);
      rd(2'd2, "events_cleared");

      // Button 0: glitch then timed hold
      btn_glitch(0, 10);
      @(negedge clk);
      i_btn[0] = 1'b1;
      for (int unsigned i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 17) chk("btn_int_early", o_btn_int, 0);
         if (i == 18) chk("btn_int_ontime", o_btn_int, 1);
      end
      m_btn[0] = 1'b1; m_bvalid = 1'b1;
      rd(2'd0, "btn0_state");
      i_btn[0] = 1'b0;
      repeat (24) @(negedge clk);
      m_btn[0] = 1'b0;
      wr(2'd2, 32'h2000_0000);
      rd(2'd2, "bvalid_cleared");

      // Manual mode: keymap frozen, column driven from register 3
      wr(2'd0, 32'h8000_0000);
      keys[5] = 1'b1;
      settle_keys();
      rd(2'd1, "manual_keymap_frozen");
      keys[5] = 1'b0;
      wr(2'd3, 32'h0000_000E);
      ovr_en = 1'b1; ovr_val = 4'b1011;
      repeat (3) @(negedge clk);
      chk("manual_kp_col", o_kp_col, 4'b1110);
      rd(2'd3, "manual_reg3");
      chk("manual_reg3_const", exp_reg(2'd3), 32'h0000_0B0E);
      ovr_en = 1'b0;
      wr(2'd0, 32'h8001_0000);
      settle_keys();

      // Randomised operations in auto mode
      for (int unsigned it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               d = $urandom & 32'h7FFF_FFFF;
               wr(2'd0, d);
               rd(2'd0, "rand_led");
            end
            1: begin
               n = $urandom_range(0, 15);
               keys[n] = ~keys[n];
               settle_keys();
               rd(2'd1, "rand_keymap");
               rd(2'd2, "rand_key_event");
            end
            2: begin
               d = '0;
               d[31] = 1'($urandom_range(0, 1));
               d[29] = 1'($urandom_range(0, 1));
               wr(2'd2, d);
               rd(2'd2, "rand_clear");
            end
            3: btn_glitch($urandom_range(0, 1), $urandom_range(1, 12));
            default: btn_hold($urandom_range(0, 1), $urandom_range(20, 40));
         endcase
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
